// File: rtl/load_store_unit_if.sv
// Load/store unit bus bundle: control-side request/response plus the
// data-memory request/ack handshake. The LSU takes the master view and the
// surrounding pipeline/memory take the slave view.
interface load_store_unit_if;
  // control side
  logic        start;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] rd_mem;
  // data memory side
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    input  start, is_store, funct3, addr, wr_data, mem_rdata, mem_ack,
    output busy, done, err, rd_mem, mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport slave (
    output start, is_store, funct3, addr, wr_data, mem_rdata, mem_ack,
    input  busy, done, err, rd_mem, mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one load or store from control, checks legality
// and alignment, issues a single word-aligned memory request with byte
// enables and lane-replicated store data, waits for the ack (bounded by
// TIMEOUT cycles) and returns the sign/zero-extended load result.
// All outputs are registered; reset is synchronous and active-high.
module load_store_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  load_store_unit_if.master   bus
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  // Legal opcode check: loads of every width, stores only for the signed
  // encodings (there is no unsigned store).
  function automatic logic access_legal(input logic [2:0] f3, input logic st);
    logic ok;
    case (f3)
      3'b000, 3'b001, 3'b010: ok = 1'b1;
      3'b100, 3'b101:         ok = ~st;
      default:                ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Natural alignment for the access size encoded in f3[1:0].
  function automatic logic access_aligned(input logic [1:0] sz, input logic [1:0] off);
    logic ok;
    case (sz)
      2'b00:   ok = 1'b1;
      2'b01:   ok = ~off[0];
      2'b10:   ok = (off == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Little-endian byte enables for the access size and byte offset.
  function automatic logic [3:0] byte_enables(input logic [1:0] sz, input logic [1:0] off);
    logic [3:0] be;
    case (sz)
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = 4'b0011 << off;
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Replicate store data across all lanes so the enabled lanes carry it.
  function automatic logic [31:0] store_lanes(input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] w;
    case (sz)
      2'b00:   w = {4{d[7:0]}};
      2'b01:   w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  // Pick the addressed lane out of the read word and extend it.
  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'b00:   b = w[7:0];
      2'b01:   b = w[15:8];
      2'b10:   b = w[23:16];
      2'b11:   b = w[31:24];
      default: b = 8'h00;
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b100:  r = {24'h000000, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b101:  r = {16'h0000, h};
      3'b010:  r = w;
      default: r = w;
    endcase
    return r;
  endfunction

  state_t      state_r,     state_nxt_s;
  logic        mem_req_r,   mem_req_nxt_s;
  logic        mem_we_r,    mem_we_nxt_s;
  logic [31:0] mem_addr_r,  mem_addr_nxt_s;
  logic [3:0]  mem_be_r,    mem_be_nxt_s;
  logic [31:0] mem_wdata_r, mem_wdata_nxt_s;
  logic        busy_r,      busy_nxt_s;
  logic        done_r,      done_nxt_s;
  logic        err_r,       err_nxt_s;
  logic [31:0] rd_mem_r,    rd_mem_nxt_s;
  logic [CNT_W-1:0] cnt_r,  cnt_nxt_s;
  logic        req_store_r,  req_store_nxt_s;
  logic [2:0]  req_funct3_r, req_funct3_nxt_s;
  logic [1:0]  req_off_r,    req_off_nxt_s;

  logic        dec_ok_s;
  logic [3:0]  dec_be_s;
  logic [31:0] dec_wdata_s;
  logic [31:0] ld_result_s;

  assign dec_ok_s    = access_legal(bus.funct3, bus.is_store)
                       & access_aligned(bus.funct3[1:0], bus.addr[1:0]);
  assign dec_be_s    = byte_enables(bus.funct3[1:0], bus.addr[1:0]);
  assign dec_wdata_s = bus.is_store ? store_lanes(bus.funct3[1:0], bus.wr_data) : 32'h0000_0000;
  assign ld_result_s = load_extend(req_funct3_r, req_off_r, bus.mem_rdata);

  // Next-state and next-output logic for the IDLE/WAIT request machine.
  always_comb begin
    state_nxt_s      = state_r;
    mem_req_nxt_s    = mem_req_r;
    mem_we_nxt_s     = mem_we_r;
    mem_addr_nxt_s   = mem_addr_r;
    mem_be_nxt_s     = mem_be_r;
    mem_wdata_nxt_s  = mem_wdata_r;
    done_nxt_s       = 1'b0;
    err_nxt_s        = 1'b0;
    rd_mem_nxt_s     = rd_mem_r;
    cnt_nxt_s        = cnt_r;
    req_store_nxt_s  = req_store_r;
    req_funct3_nxt_s = req_funct3_r;
    req_off_nxt_s    = req_off_r;

    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          if (dec_ok_s) begin
            state_nxt_s      = ST_WAIT;
            mem_req_nxt_s    = 1'b1;
            mem_we_nxt_s     = bus.is_store;
            mem_addr_nxt_s   = {bus.addr[31:2], 2'b00};
            mem_be_nxt_s     = dec_be_s;
            mem_wdata_nxt_s  = dec_wdata_s;
            cnt_nxt_s        = {CNT_W{1'b0}};
            req_store_nxt_s  = bus.is_store;
            req_funct3_nxt_s = bus.funct3;
            req_off_nxt_s    = bus.addr[1:0];
          end else begin
            err_nxt_s = 1'b1;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (bus.mem_ack) begin
          // ack wins over a timeout firing on the same edge
          state_nxt_s     = ST_IDLE;
          mem_req_nxt_s   = 1'b0;
          mem_we_nxt_s    = 1'b0;
          mem_addr_nxt_s  = 32'h0000_0000;
          mem_be_nxt_s    = 4'b0000;
          mem_wdata_nxt_s = 32'h0000_0000;
          done_nxt_s      = 1'b1;
          if (!req_store_r) begin
            rd_mem_nxt_s = ld_result_s;
          end else begin
            rd_mem_nxt_s = rd_mem_r;
          end
        end else if (cnt_r == CNT_LAST) begin
          state_nxt_s     = ST_IDLE;
          mem_req_nxt_s   = 1'b0;
          mem_we_nxt_s    = 1'b0;
          mem_addr_nxt_s  = 32'h0000_0000;
          mem_be_nxt_s    = 4'b0000;
          mem_wdata_nxt_s = 32'h0000_0000;
          err_nxt_s       = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_nxt_s     = ST_IDLE;
        mem_req_nxt_s   = 1'b0;
        mem_we_nxt_s    = 1'b0;
        mem_addr_nxt_s  = 32'h0000_0000;
        mem_be_nxt_s    = 4'b0000;
        mem_wdata_nxt_s = 32'h0000_0000;
      end
    endcase

    busy_nxt_s = (state_nxt_s != ST_IDLE);
  end

  // State and registered outputs, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      mem_req_r    <= 1'b0;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= 32'h0000_0000;
      mem_be_r     <= 4'b0000;
      mem_wdata_r  <= 32'h0000_0000;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      err_r        <= 1'b0;
      rd_mem_r     <= 32'h0000_0000;
      cnt_r        <= {CNT_W{1'b0}};
      req_store_r  <= 1'b0;
      req_funct3_r <= 3'b000;
      req_off_r    <= 2'b00;
    end else begin
      state_r      <= state_nxt_s;
      mem_req_r    <= mem_req_nxt_s;
      mem_we_r     <= mem_we_nxt_s;
      mem_addr_r   <= mem_addr_nxt_s;
      mem_be_r     <= mem_be_nxt_s;
      mem_wdata_r  <= mem_wdata_nxt_s;
      busy_r       <= busy_nxt_s;
      done_r       <= done_nxt_s;
      err_r        <= err_nxt_s;
      rd_mem_r     <= rd_mem_nxt_s;
      cnt_r        <= cnt_nxt_s;
      req_store_r  <= req_store_nxt_s;
      req_funct3_r <= req_funct3_nxt_s;
      req_off_r    <= req_off_nxt_s;
    end
  end

  assign bus.mem_req   = mem_req_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_be    = mem_be_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.err       = err_r;
  assign bus.rd_mem    = rd_mem_r;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter TIMEOUT, default 16: maximum number of cycles the block waits for mem_ack before aborting.
REQ-002 clk  in  1  system clock; all state updates on the rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 start  in  1  one-cycle request from control; sampled only in IDLE.
REQ-005 is_store  in  1  1 = store, 0 = load; sampled with start.
REQ-006 funct3  in  3  access type: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU; sampled with start.
REQ-007 addr  in  32  byte address (ALU result); sampled with start.
REQ-008 wr_data  in  32  store data (rs2); sampled with start.
REQ-009 mem_rdata  in  32  word read from data memory; valid in the cycle mem_ack=1.
REQ-010 mem_ack  in  1  memory completion; one cycle wide.
REQ-011 mem_req  out  1  memory request; registered.
REQ-012 mem_we  out  1  write enable; valid while mem_req=1.
REQ-013 mem_addr  out  32  word-aligned address {addr[31:2],2'b00}.
REQ-014 mem_be  out  4  byte enables; little-endian.
REQ-015 mem_wdata  out  32  lane-replicated store data.
REQ-016 busy  out  1  pipeline stall; 1 whenever state is not IDLE.
REQ-017 done  out  1  one-cycle pulse when an access completes successfully.
REQ-018 err  out  1  one-cycle pulse on misalignment, illegal funct3, or timeout.
REQ-019 rd_mem  out  32  extended load result for the writeback mux; held until the next successful load.

Function
REQ-020 States: IDLE, WAIT. Encoding is free.
REQ-021 IDLE with start=1 and a legal, aligned access: latch all request fields, assert mem_req on the next edge, clear the timeout counter, and go to WAIT.
REQ-022 Legal alignment: byte accesses at any address; halfword accesses need addr[0]=0; word accesses need addr[1:0]=00.
REQ-023 IDLE with start=1 and a misaligned access or illegal funct3 (011, 110, 111, or 100/101 with is_store=1): pulse err for one cycle on the next edge, never assert mem_req, and remain in IDLE.
REQ-024 start while busy=1 is ignored.
REQ-025 In WAIT, mem_req, mem_we, mem_addr, mem_be and mem_wdata stay constant until the request ends.
REQ-026 Byte enables: byte access gives 4'b0001<<addr[1:0]; halfword gives 4'b0011<<addr[1:0]; word gives 4'b1111. Loads and stores use the same enables.
REQ-027 Store data: SB gives {4{wr_data[7:0]}}; SH gives {2{wr_data[15:0]}}; SW gives wr_data. For loads, mem_wdata = 0.
REQ-028 WAIT with mem_ack=1: on the same edge, drop mem_req, go to IDLE, and pulse done on that edge.
REQ-029 For a load, the same edge also writes rd_mem as follows, selecting the lane by the latched addr[1:0]:
- LB and LH sign-extend the byte or halfword.
- LBU and LHU zero-extend it.
- LW passes the word unchanged.
REQ-030 A store never changes rd_mem.
REQ-031 Timeout: the counter increments each WAIT cycle with mem_ack=0. When it reaches TIMEOUT-1 without an ack, the next edge drops mem_req, returns to IDLE, pulses err, and leaves rd_mem unchanged.
REQ-032 mem_ack=1 on the cycle the timeout would fire: the ack wins, giving done and no err.
REQ-033 mem_ack while in IDLE is ignored.
REQ-034 done and err are never asserted in the same cycle.
REQ-035 Latency with ack in the first WAIT cycle: start at edge N, mem_req high from N, done at N+1, and busy returns to 0 after N+1.

Reset
REQ-036 rst=1 at an edge forces IDLE and sets all of these to 0:
- mem_req, mem_we, mem_addr, mem_be, mem_wdata
- busy, done, err, rd_mem
- timeout counter
REQ-037 Reset during WAIT abandons the access with no done or err pulse; an ack arriving after reset is ignored.
REQ-038 start during rst=1 is ignored.

Verification
REQ-039 LW at addr 0x100, ack one cycle after mem_req, mem_rdata=0xDEADBEEF -> rd_mem=0xDEADBEEF, done pulses once, busy high for exactly one cycle.
REQ-040 LB at 0x103, then LBU at 0x103, both with mem_rdata=0x80FF1234 -> rd_mem=0xFFFFFF80, then 0x00000080.
REQ-041 SH at 0x102 with wr_data=0x0000ABCD -> mem_be=1100, mem_wdata=0xABCDABCD, mem_we=1, rd_mem unchanged.
REQ-042 LW at 0x101, then SH at 0x003 -> err pulses for each, mem_req never asserted, busy stays 0.
REQ-043 LW at 0x200 with no ack, TIMEOUT=16 -> mem_req high for 16 cycles, then err pulses; a later ack is ignored.
REQ-044 rst asserted in the third WAIT cycle -> all outputs 0 next cycle; no done or err; an ack two cycles later has no effect.
